// File: rtl/fifo_nd.sv
// fifo_nd -- parametrised single-clock FIFO with first-word-fall-through output.
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (>= 2, any value, not only powers of two)
//   AF_LEVEL  ALMOST_FULL  asserts when COUNT >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  ALMOST_EMPTY asserts when COUNT <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RST           synchronous active-high reset, overrides every other input
//   D_IN          write data
//   ENQ / DEQ     enqueue / dequeue requests, sampled at the edge
//   CLR           synchronous flush, same effect as RST, priority over ENQ/DEQ
//   D_OUT         head-of-queue word, 0 while empty
//   EMPTY_N       1 = at least one entry held
//   FULL_N        1 = at least one free slot
//   COUNT         current occupancy
//   ALMOST_FULL   COUNT >= AF_LEVEL
//   ALMOST_EMPTY  COUNT <= AE_LEVEL
//   OVERFLOW      sticky: an ENQ was dropped while full
//   UNDERFLOW     sticky: a DEQ was issued while empty
//
// Every output is a flop; the next values are computed from the current
// registered state plus this cycle's requests, so no output has a
// combinational path from ENQ, DEQ or D_IN.
module fifo_nd #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           D_IN,
  input  logic                       ENQ,
  input  logic                       DEQ,
  input  logic                       CLR,
  output logic [WIDTH-1:0]           D_OUT,
  output logic                       EMPTY_N,
  output logic                       FULL_N,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wp_r;
  logic [PW-1:0]    rp_r;
  logic [CW-1:0]    cnt_r;

  logic             is_full_s;
  logic             is_empty_s;
  logic             enq_acc_s;
  logic             deq_acc_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [PW-1:0]    wp_next_s;
  logic [PW-1:0]    rp_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Request acceptance, error detection and next-state values.
  always_comb begin
    is_full_s   = (cnt_r == CNT_FULL);
    is_empty_s  = (cnt_r == '0);
    // A full FIFO still accepts a write when a read frees the head slot.
    enq_acc_s   = ENQ && (!is_full_s || DEQ);
    deq_acc_s   = DEQ && !is_empty_s;
    ovf_set_s   = ENQ && is_full_s && !DEQ;
    unf_set_s   = DEQ && is_empty_s;
    wp_next_s   = enq_acc_s ? next_ptr(wp_r) : wp_r;
    rp_next_s   = deq_acc_s ? next_ptr(rp_r) : rp_r;
    case ({enq_acc_s, deq_acc_s})
      2'b10:   cnt_next_s = cnt_r + CW'(1);
      2'b01:   cnt_next_s = cnt_r - CW'(1);
      default: cnt_next_s = cnt_r;
    endcase
    // The word being written becomes the head when nothing else remains
    // ahead of it; the array write has not landed yet, so bypass D_IN.
    if (cnt_next_s == '0) begin
      head_next_s = '0;
    end else if (enq_acc_s && (wp_r == rp_next_s)) begin
      head_next_s = D_IN;
    end else begin
      head_next_s = mem_r[rp_next_s];
    end
  end

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (!RST && !CLR && enq_acc_s) begin
      mem_r[wp_r] <= D_IN;
    end
  end

  // Pointers, occupancy, registered status outputs and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      wp_r         <= '0;
      rp_r         <= '0;
      cnt_r        <= '0;
      D_OUT        <= '0;
      EMPTY_N      <= 1'b0;
      FULL_N       <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      wp_r         <= wp_next_s;
      rp_r         <= rp_next_s;
      cnt_r        <= cnt_next_s;
      D_OUT        <= head_next_s;
      EMPTY_N      <= (cnt_next_s != '0);
      FULL_N       <= (cnt_next_s != CNT_FULL);
      ALMOST_FULL  <= (cnt_next_s >= AF_CNT);
      ALMOST_EMPTY <= (cnt_next_s <= AE_CNT);
      OVERFLOW     <= OVERFLOW | ovf_set_s;
      UNDERFLOW    <= UNDERFLOW | unf_set_s;
    end
  end

  assign COUNT = cnt_r;

endmodule

// File: tb/tb_fifo_nd.sv
// tb_fifo_nd -- self-checking bench for fifo_nd.
// Two instances (DEPTH=16 and DEPTH=5, WIDTH=8) share one stimulus stream.
// Each is shadowed by a queue-based reference model; every output of both
// instances is compared after every edge, and directed steps add explicit
// expectations for the fill/drain, overflow, underflow, wrap and CLR cases.
module tb_fifo_nd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       enq = 1'b0;
  logic       deq = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] d_out16, d_out5;
  logic       empty_n16, full_n16, af16, ae16, ovf16, unf16;
  logic       empty_n5, full_n5, af5, ae5, ovf5, unf5;
  logic [4:0] count16;
  logic [2:0] count5;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q16[$];
  logic [7:0] q5[$];
  bit m_ovf16 = 1'b0, m_unf16 = 1'b0, m_ovf5 = 1'b0, m_unf5 = 1'b0;

  fifo_nd #(.WIDTH(8), .DEPTH(16)) dut16 (
    .CLK(clk), .RST(rst), .D_IN(d_in), .ENQ(enq), .DEQ(deq), .CLR(clr),
    .D_OUT(d_out16), .EMPTY_N(empty_n16), .FULL_N(full_n16), .COUNT(count16),
    .ALMOST_FULL(af16), .ALMOST_EMPTY(ae16), .OVERFLOW(ovf16), .UNDERFLOW(unf16)
  );

  fifo_nd #(.WIDTH(8), .DEPTH(5)) dut5 (
    .CLK(clk), .RST(rst), .D_IN(d_in), .ENQ(enq), .DEQ(deq), .CLR(clr),
    .D_OUT(d_out5), .EMPTY_N(empty_n5), .FULL_N(full_n5), .COUNT(count5),
    .ALMOST_FULL(af5), .ALMOST_EMPTY(ae5), .OVERFLOW(ovf5), .UNDERFLOW(unf5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decide what one edge does to a queue of occupancy sz and capacity dep:
  // returns {push, pop, overflow, underflow}.
  function automatic logic [3:0] decide(input int sz, input int dep, input bit e, input bit d);
    bit full, empty;
    full  = (sz == dep);
    empty = (sz == 0);
    return {e && (!full || d), d && !empty, e && full && !d, d && empty};
  endfunction

  task automatic check_one(input string n, input int sz, input logic [7:0] head,
                           input int dep, input int afl, input int ael,
                           input bit movf, input bit munf,
                           input logic [7:0] dout, input logic en, input logic fn,
                           input int cnt, input logic afo, input logic aeo,
                           input logic ovo, input logic uno);
    check({n, ".D_OUT"}, 32'(dout), (sz != 0) ? 32'(head) : 32'h0);
    check({n, ".COUNT"}, 32'(cnt), 32'(sz));
    check({n, ".EMPTY_N"}, 32'(en), 32'(sz != 0));
    check({n, ".FULL_N"}, 32'(fn), 32'(sz != dep));
    check({n, ".ALMOST_FULL"}, 32'(afo), 32'(sz >= afl));
    check({n, ".ALMOST_EMPTY"}, 32'(aeo), 32'(sz <= ael));
    check({n, ".OVERFLOW"}, 32'(ovo), 32'(movf));
    check({n, ".UNDERFLOW"}, 32'(uno), 32'(munf));
  endtask

  // One clock: drive inputs, advance both models at the edge, compare 1 time unit later.
  task automatic cyc(input bit e, input bit d, input logic [7:0] din, input bit c, input bit r);
    logic [3:0] a;
    enq = e; deq = d; d_in = din; clr = c; rst = r;
    @(posedge clk);
    if (r || c) begin
      q16.delete(); q5.delete();
      m_ovf16 = 1'b0; m_unf16 = 1'b0; m_ovf5 = 1'b0; m_unf5 = 1'b0;
    end else begin
      a = decide(q16.size(), 16, e, d);
      if (a[2]) void'(q16.pop_front());
      if (a[3]) q16.push_back(din);
      m_ovf16 |= a[1]; m_unf16 |= a[0];
      a = decide(q5.size(), 5, e, d);
      if (a[2]) void'(q5.pop_front());
      if (a[3]) q5.push_back(din);
      m_ovf5 |= a[1]; m_unf5 |= a[0];
    end
    #1;
    check_one("d16", q16.size(), (q16.size() != 0) ? q16[0] : 8'h00, 16, 14, 2,
              m_ovf16, m_unf16, d_out16, empty_n16, full_n16, 32'(count16),
              af16, ae16, ovf16, unf16);
    check_one("d5", q5.size(), (q5.size() != 0) ? q5[0] : 8'h00, 5, 3, 2,
              m_ovf5, m_unf5, d_out5, empty_n5, full_n5, 32'(count5),
              af5, ae5, ovf5, unf5);
  endtask

  initial begin
    logic [7:0] wv;
    logic [7:0] exp_rd;
    int         sz;
    int         r;

    // Reset held two cycles, then one idle cycle.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst.EMPTY_N", 32'(empty_n16), 32'h0);
    check("rst.FULL_N", 32'(full_n16), 32'h1);
    check("rst.COUNT", 32'(count16), 32'h0);
    check("rst.D_OUT", 32'(d_out16), 32'h0);
    check("rst.ALMOST_EMPTY", 32'(ae16), 32'h1);
    check("rst.ALMOST_FULL", 32'(af16), 32'h0);
    check("rst.OVERFLOW", 32'(ovf16), 32'h0);
    check("rst.UNDERFLOW", 32'(unf16), 32'h0);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      if (i == 13) check("fill.af_at13", 32'(af16), 32'h0);
      if (i == 14) check("fill.af_at14", 32'(af16), 32'h1);
      if (i == 15) check("fill.full_n_at15", 32'(full_n16), 32'h1);
    end
    check("fill.FULL_N", 32'(full_n16), 32'h0);
    check("fill.COUNT", 32'(count16), 32'd16);

    // Drain: words come back in order, then empty with D_OUT=0.
    for (int i = 1; i <= 16; i++) begin
      check("drain.D_OUT", 32'(d_out16), 32'(i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    check("drain.EMPTY_N", 32'(empty_n16), 32'h0);
    check("drain.D_OUT0", 32'(d_out16), 32'h0);

    // Refill, then overflow and pass-through at full.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    check("ovf.OVERFLOW", 32'(ovf16), 32'h1);
    check("ovf.COUNT", 32'(count16), 32'd16);
    cyc(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
    check("pass.COUNT", 32'(count16), 32'd16);
    check("pass.D_OUT", 32'(d_out16), 32'h42);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("pass.last_word", 32'(d_out16), 32'hBB);
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end

    // Underflow with a simultaneous write.
    cyc(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0);
    check("unf.UNDERFLOW", 32'(unf16), 32'h1);
    check("unf.COUNT", 32'(count16), 32'd1);
    check("unf.D_OUT", 32'(d_out16), 32'h5C);

    // CLR priority at COUNT=7 with both sticky flags set.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    check("clr.pre_COUNT", 32'(count16), 32'd7);
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    check("clr.COUNT", 32'(count16), 32'h0);
    check("clr.EMPTY_N", 32'(empty_n16), 32'h0);
    check("clr.OVERFLOW", 32'(ovf16), 32'h0);
    check("clr.UNDERFLOW", 32'(unf16), 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("clr.nothing_written", 32'(count16), 32'h0);

    // Wrap-around on the DEPTH=5 instance, occupancy kept within 1..4.
    wv = 8'h30;
    exp_rd = 8'h30;
    cyc(1'b1, 1'b0, wv, 1'b0, 1'b0);
    wv++;
    for (int i = 0; i < 23; i++) begin
      sz = q5.size();
      r = int'($urandom_range(0, 2));
      if (r == 1 && sz < 4) begin
        cyc(1'b1, 1'b0, wv, 1'b0, 1'b0);
        wv++;
      end else begin
        check("wrap.D_OUT", 32'(d_out5), 32'(exp_rd));
        exp_rd++;
        if (r == 2 && sz > 1) begin
          cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end else begin
          cyc(1'b1, 1'b1, wv, 1'b0, 1'b0);
          wv++;
        end
      end
    end
    check("wrap.OVERFLOW", 32'(ovf5), 32'h0);
    check("wrap.UNDERFLOW", 32'(unf5), 32'h0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
